// File: rtl/debouncer.sv
// Debouncer: qualifies a level change on a raw contact input by requiring it to hold
// for P_STABLE consecutive samples. Optional two-flop input synchronizer: DEBOUNCER_SYNC_EN.
module debouncer #(
  parameter int unsigned P_STABLE = 1000,
  parameter logic        P_INIT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_out,
  output logic o_busy,
  output logic o_glitch
);

  localparam int unsigned CW = $clog2(P_STABLE + 1);

  // o_busy is a direct decode of this state register, so it doubles as the FSM debug view.
  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          glitch_q, glitch_d;
  logic          s;
  logic          last_sample;

`ifdef DEBOUNCER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= P_INIT;
      sync2_q <= P_INIT;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = i_in;
`endif

  // The candidate is accepted on the sample that brings the run length up to P_STABLE.
  assign last_sample = ((32'(cnt_q) + 32'd1) == P_STABLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    glitch_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != out_q) begin
          if (P_STABLE == 32'd1) begin
            out_d = s;
          end else begin
            cnt_d   = CW'(1);
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (s != out_q) begin
          if (last_sample) begin
            out_d   = s;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d    = '0;
          state_d  = ST_STABLE;
          glitch_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      out_q    <= P_INIT;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      glitch_q <= glitch_d;
    end
  end

  assign o_out    = out_q;
  assign o_busy   = (state_q == ST_CHECK);
  assign o_glitch = glitch_q;

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: three instances (P_STABLE 4/1/3) checked every cycle against a
// run-length model of the accept/reject rules, plus hand-computed directed scenarios.
module tb_debouncer;

  localparam int N = 3;
  localparam int unsigned P_A = 4, P_B = 1, P_C = 3;
  localparam logic INIT_A = 1'b0, INIT_B = 1'b0, INIT_C = 1'b1;
`ifdef DEBOUNCER_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  logic i_in;
  always #5 clk = ~clk;

  logic out_a, busy_a, glitch_a;
  logic out_b, busy_b, glitch_b;
  logic out_c, busy_c, glitch_c;

  debouncer #(.P_STABLE(P_A), .P_INIT(INIT_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_in(i_in),
    .o_out(out_a), .o_busy(busy_a), .o_glitch(glitch_a)
  );
  debouncer #(.P_STABLE(P_B), .P_INIT(INIT_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_in(i_in),
    .o_out(out_b), .o_busy(busy_b), .o_glitch(glitch_b)
  );
  debouncer #(.P_STABLE(P_C), .P_INIT(INIT_C)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_in(i_in),
    .o_out(out_c), .o_busy(busy_c), .o_glitch(glitch_c)
  );

  logic [N-1:0] d_out, d_busy, d_glitch;
  assign d_out    = {out_c, out_b, out_a};
  assign d_busy   = {busy_c, busy_b, busy_a};
  assign d_glitch = {glitch_c, glitch_b, glitch_a};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a change is accepted once the trailing run of samples that differ
  // from the output reaches P; a run cut short by a matching sample is a glitch.
  int unsigned p_of[N]    = '{P_A, P_B, P_C};
  logic        init_of[N] = '{INIT_A, INIT_B, INIT_C};
  logic        m_out[N], m_busy[N], m_glitch[N];
  logic        sy1[N], sy2[N];
  int unsigned run[N];
  logic        s_v;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      s_v = SYNC ? sy2[i] : i_in;
      if (rst) begin
        sy1[i] = init_of[i];
        sy2[i] = init_of[i];
      end else begin
        sy2[i] = sy1[i];
        sy1[i] = i_in;
      end
      if (rst) begin
        m_out[i]    = init_of[i];
        run[i]      = 0;
        m_glitch[i] = 1'b0;
      end else if (s_v != m_out[i]) begin
        m_glitch[i] = 1'b0;
        run[i]++;
        if (run[i] == p_of[i]) begin
          m_out[i] = s_v;
          run[i]   = 0;
        end
      end else begin
        m_glitch[i] = (run[i] != 0);
        run[i]      = 0;
      end
      m_busy[i] = (run[i] != 0);
    end
    if (rst) model_valid = 1'b1;
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_out[%0d]", i), d_out[i], m_out[i]);
        chk($sformatf("model_busy[%0d]", i), d_busy[i], m_busy[i]);
        chk($sformatf("model_glitch[%0d]", i), d_glitch[i], m_glitch[i]);
      end
    end
  end

  // Driver: apply inputs right after a negedge, return after the next negedge
  task automatic cyc(input logic rst_v, input logic in_v);
    rst  = rst_v;
    i_in = in_v;
    @(negedge clk);
  endtask

  int gc;
  int remaining;
  logic lvl;

  initial begin
    rst  = 1'b1;
    i_in = 1'b0;
    @(negedge clk);

`ifndef DEBOUNCER_SYNC_EN
    // Reset held with i_in high; rise on the 4th edge after release
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      chk("rst_out", out_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_glitch", glitch_a, 1'b0);
    end
    chk("rst_init_c", out_c, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      chk("rel_out_low", out_a, 1'b0);
    end
    cyc(1'b0, 1'b1);
    chk("rel_out_rise", out_a, 1'b1);

    // Clean 0->1 held 10 cycles
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("clean_k_busy", busy_a, 1'b1);
    chk("clean_k_out", out_a, 1'b0);
    chk("p1_out_immediate", out_b, 1'b1);
    chk("p1_busy_never", busy_b, 1'b0);
    cyc(1'b0, 1'b1);
    chk("clean_k1_busy", busy_a, 1'b1);
    cyc(1'b0, 1'b1);
    chk("clean_k2_busy", busy_a, 1'b1);
    chk("clean_k2_out", out_a, 1'b0);
    cyc(1'b0, 1'b1);
    chk("clean_k3_out", out_a, 1'b1);
    chk("clean_k3_busy", busy_a, 1'b0);
    gc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      gc += int'(glitch_a);
    end
    chk_int("clean_no_glitch", gc, 0);
    chk("clean_hold_out", out_a, 1'b1);

    // Short pulse rejected
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("short_glitch", glitch_a, 1'b1);
    chk("short_busy", busy_a, 1'b0);
    chk("short_out", out_a, 1'b0);
    cyc(1'b0, 1'b0);
    chk("short_glitch_one_cycle", glitch_a, 1'b0);

    // Bounce 1,0,1,0 then steady 1
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    gc = 0;
    cyc(1'b0, 1'b1); gc += int'(glitch_a);
    cyc(1'b0, 1'b0); gc += int'(glitch_a);
    cyc(1'b0, 1'b1); gc += int'(glitch_a);
    cyc(1'b0, 1'b0); gc += int'(glitch_a);
    chk_int("bounce_glitches", gc, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      chk("bounce_out_low", out_a, 1'b0);
    end
    cyc(1'b0, 1'b1);
    chk("bounce_out_rise", out_a, 1'b1);

    // Reset mid-qualification
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("midrst_out", out_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_glitch", glitch_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1);
      chk("midrst_requal_low", out_a, 1'b0);
      chk("midrst_requal_noglitch", glitch_a, 1'b0);
    end
    cyc(1'b0, 1'b1);
    chk("midrst_requal_rise", out_a, 1'b1);
`else
    // P_STABLE=1 behind the synchronizer: rise two edges after the input change
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("sync_k_out", out_b, 1'b0);
    cyc(1'b0, 1'b1);
    chk("sync_k1_out", out_b, 1'b0);
    cyc(1'b0, 1'b1);
    chk("sync_k2_out", out_b, 1'b1);
    chk("sync_init_c", out_c, 1'b1);
`endif

    // Randomized bursts of varying length, occasional reset
    lvl       = 1'b0;
    remaining = 0;
    for (int n = 0; n < 3000; n++) begin
      if (remaining == 0) begin
        lvl       = ~lvl;
        remaining = int'($urandom_range(1, 7));
      end
      remaining--;
      cyc(($urandom_range(0, 199) == 0), lvl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
